// File: rtl/commit_trace_buffer.sv
// Retirement trace FIFO: captures retired PCs with a sequence number and a
// discontinuity flag, drains them first-word-fall-through over valid/ready.
module commit_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_trace_en,
    input  logic                   i_clear,
    input  logic [31:0]            i_pc_debug,
    input  logic                   i_insn_vld,
    output logic                   o_trace_valid,
    input  logic                   i_trace_ready,
    output logic [31:0]            o_trace_pc,
    output logic [SEQ_W-1:0]       o_trace_seq,
    output logic                   o_trace_jump,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_overflow,
    output logic [15:0]            o_drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 32 + SEQ_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [SEQ_W-1:0] seq_reg, seq_next;
    logic [31:0]      last_pc_reg, last_pc_next;
    logic             first_reg, first_next;
    logic             overflow_reg, overflow_next;
    logic [15:0]      drop_cnt_reg, drop_cnt_next;

    logic             capture;
    logic             pop;
    logic             push;
    logic             drop;
    logic             jump;
    logic [EW-1:0]    wr_entry;
    logic [EW-1:0]    head_entry;
    logic [EW-1:0]    entry_flat [DEPTH];

    assign capture  = i_trace_en & i_insn_vld;
    assign pop      = (count_reg != '0) & i_trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = capture & ((count_reg != FULL_CNT) | pop);
    assign drop     = capture & (count_reg == FULL_CNT) & ~pop;
    assign jump     = first_reg | (i_pc_debug != (last_pc_reg + 32'd4));
    assign wr_entry = {i_pc_debug, seq_reg, jump};

    // Storage carries no reset; occupancy alone decides what is valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [EW-1:0] entry_reg;

            always_ff @(posedge i_clk) begin
                if (push && !i_clear && (wr_ptr_reg == PW'(gi))) begin
                    entry_reg <= wr_entry;
                end
            end

            assign entry_flat[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        seq_next      = seq_reg;
        last_pc_next  = last_pc_reg;
        first_next    = first_reg;
        overflow_next = overflow_reg;
        drop_cnt_next = drop_cnt_reg;

        if (i_clear) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            seq_next      = '0;
            last_pc_next  = '0;
            first_next    = 1'b1;
            overflow_next = 1'b0;
            drop_cnt_next = '0;
        end else begin
            // Dropped commits still advance seq and last_pc so gaps stay visible.
            if (capture) begin
                last_pc_next = i_pc_debug;
                first_next   = 1'b0;
                seq_next     = seq_reg + SEQ_W'(1);
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CW'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CW'(1);
            end
            if (drop) begin
                overflow_next = 1'b1;
                if (drop_cnt_reg != 16'hFFFF) begin
                    drop_cnt_next = drop_cnt_reg + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            seq_reg      <= '0;
            last_pc_reg  <= '0;
            first_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            seq_reg      <= seq_next;
            last_pc_reg  <= last_pc_next;
            first_reg    <= first_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign head_entry    = entry_flat[rd_ptr_reg];
    assign o_trace_valid = (count_reg != '0);
    assign o_trace_pc    = o_trace_valid ? head_entry[EW-1 -: 32] : 32'd0;
    assign o_trace_seq   = o_trace_valid ? head_entry[SEQ_W:1] : '0;
    assign o_trace_jump  = o_trace_valid & head_entry[0];
    assign o_count       = count_reg;
    assign o_full        = (count_reg == FULL_CNT);
    assign o_overflow    = overflow_reg;
    assign o_drop_cnt    = drop_cnt_reg;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
Downstream consumer of the single-cycle core's retirement debug outputs (o_pc_debug, o_insn_vld). Captures the PC of each retired instruction into a FIFO, tags each entry with a sequence number and a control-flow-discontinuity flag, and drains entries over a valid/ready interface to a debug/UART/LED consumer. Overflow is tracked explicitly, so the consumer can tell when trace data has been lost.

Parameters:
DEPTH, 16, FIFO entries; power of two, >=2
SEQ_W, 16, sequence-number width in bits

Ports:
i_clk  input  1  clock, all state on rising edge
i_reset  input  1  asynchronous, active-low reset (0 = reset)
i_trace_en  input  1  capture enable
i_clear  input  1  synchronous flush of FIFO and all counters
i_pc_debug  input  32  retired PC from core
i_insn_vld  input  1  retired-instruction strobe from core
o_trace_valid  output  1  head entry available
i_trace_ready  input  1  consumer accepts head entry
o_trace_pc  output  32  head entry PC
o_trace_seq  output  SEQ_W  head entry sequence number
o_trace_jump  output  1  head entry is non-sequential
o_count  output  $clog2(DEPTH)+1  current occupancy
o_full  output  1  occupancy == DEPTH
o_overflow  output  1  sticky: at least one commit dropped
o_drop_cnt  output  16  dropped commits, saturating

Behaviour:
- Reset (i_reset=0, async): FIFO empty; rd/wr pointers=0; seq counter=0; last_pc=0; first flag=1; o_overflow=0; o_drop_cnt=0. All outputs read 0: o_trace_valid=0, o_count=0, o_full=0.
- Capture event: i_trace_en=1 and i_insn_vld=1 at a rising edge. No capture otherwise; i_insn_vld is ignored while i_trace_en=0.
- For every capture event, kept or dropped:
  - jump = first_flag OR (i_pc_debug != last_pc+32'd4), with modulo-2^32 add.
  - Update last_pc to i_pc_debug; clear first_flag.
  - Entry seq = current seq counter; then increment seq modulo 2^SEQ_W.
  - Because dropped commits still consume a seq number, gaps in the drained seq stream reveal where trace was lost.
- Pop: o_trace_valid=1 and i_trace_ready=1 at the edge; rd pointer advances.
- Push: capture event and (count<DEPTH or pop in same cycle); write at wr pointer, which then advances.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop: allowed at any occupancy, including full. Count is unchanged and nothing is dropped.
- Drop: capture event, count==DEPTH and no pop. Entry is discarded, o_overflow set (sticky), o_drop_cnt increments and saturates at 16'hFFFF.
- Pop when empty: ignored, since o_trace_valid=0.
- Output timing: first-word-fall-through. The head entry is on o_trace_pc/seq/jump whenever count>0; these outputs are 0 when empty.
- Latency: a commit captured at edge N is visible with o_trace_valid=1 after edge N, when the FIFO was previously empty.
- o_trace_valid = (count!=0); o_full = (count==DEPTH). Both are registered-state-derived, with no combinational path from i_insn_vld or i_trace_ready.
- Outputs hold stable while o_trace_valid=1 and i_trace_ready=0.
- i_clear=1 (synchronous, highest priority): same state as reset. Any capture or pop in that cycle is ignored.
- Reset asserted mid-operation: all contents lost immediately; no partial entries.

Test Plan:
- Reset, trace_en=1, commits PC 0x0,0x4,0x8, ready=1 -> drained seq 0,1,2; jump 1,0,0; o_count returns to 0; overflow=0.
- Commits PC 0x10,0x14,0x40,0x44 -> jump flags 1,0,1,0; the 0x40 entry has seq 2.
- ready=0, DEPTH+3=19 commits (PC 0x0 step 4) -> o_full=1, o_count=16, o_overflow=1, o_drop_cnt=3. Drain gives seq 0..15. Next commit after drain has seq 19 and jump=1, since its PC is 0x50 != 0x48+4.
- Full FIFO, ready=1 and commit in the same cycle for 5 cycles -> o_count stays 16, o_drop_cnt unchanged, drained seq stays contiguous.
- i_clear pulse with 5 entries and o_overflow=1 -> next cycle o_count=0, o_trace_valid=0, o_overflow=0, o_drop_cnt=0; next commit has seq 0, jump 1. A commit coincident with the clear is not stored.
- i_trace_en=0 with 10 commits -> o_count=0, seq unchanged. Async reset asserted between clock edges with entries present -> o_trace_valid drops to 0 immediately, before the next edge.
